// File: rtl/alu_arbiter_2ch.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter_2ch
//  Purpose  : Two-channel valid/ready arbiter for one shared combinational
//             8-bit ALU. It registers the result and flags in a one-entry
//             output buffer tagged with the issuing channel. It also keeps
//             saturating per-channel completion counters.
//  Options  : ALU_ARB_FIXED_PRIO_EN -- when defined, ch0 always wins and the
//             round-robin pointer is removed. When undefined, channels
//             alternate on simultaneous requests.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter_2ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [7:0]       req_a0,
  input  logic [7:0]       req_b0,
  input  logic [2:0]       req_op0,
  input  logic [7:0]       req_a1,
  input  logic [7:0]       req_b1,
  input  logic [2:0]       req_op1,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [7:0]       alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_id,
  output logic [7:0]       out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_overflow,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             out_valid_q,  out_valid_d;
  logic             out_id_q,     out_id_d;
  logic [7:0]       out_result_q, out_result_d;
  logic             out_carry_q,  out_carry_d;
  logic             out_zero_q,   out_zero_d;
  logic             out_ovf_q,    out_ovf_d;
  logic [CNT_W-1:0] done_cnt0_q,  done_cnt0_d;
  logic [CNT_W-1:0] done_cnt1_q,  done_cnt1_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
  // 0 = ch0 preferred on a tie, 1 = ch1 preferred
  logic             ptr_q,        ptr_d;
`endif

  logic       can_accept;
  logic [1:0] grant;
  logic       consume;

  // Grant selection: a free (or draining) buffer is required, and no
  // handshake is allowed on a reset cycle.
  always_comb begin
    can_accept = rst_n & (~out_valid_q | out_ready);
    grant      = 2'b00;
    if (can_accept) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
        2'b11:   grant = 2'b01;
`else
        2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
`endif
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign consume   = out_valid_q & out_ready;

  // Steer the granted channel's operation onto the shared ALU, zero when idle
  always_comb begin
    alu_a      = 8'h00;
    alu_b      = 8'h00;
    alu_opcode = 3'd0;
    if (grant[0]) begin
      alu_a      = req_a0;
      alu_b      = req_b0;
      alu_opcode = req_op0;
    end else if (grant[1]) begin
      alu_a      = req_a1;
      alu_b      = req_b1;
      alu_opcode = req_op1;
    end
  end

  // Next state: capture on grant (this also covers a back-to-back refill),
  // drain on consume, and count consumed results per channel
  always_comb begin
    out_valid_d  = out_valid_q;
    out_id_d     = out_id_q;
    out_result_d = out_result_q;
    out_carry_d  = out_carry_q;
    out_zero_d   = out_zero_q;
    out_ovf_d    = out_ovf_q;
    done_cnt0_d  = done_cnt0_q;
    done_cnt1_d  = done_cnt1_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    ptr_d        = ptr_q;
`endif
    if (|grant) begin
      out_valid_d  = 1'b1;
      out_id_d     = grant[1];
      out_result_d = alu_result;
      out_carry_d  = alu_carry;
      out_zero_d   = alu_zero;
      out_ovf_d    = alu_overflow;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_d        = ~grant[1];
`endif
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
    if (consume) begin
      if (!out_id_q && done_cnt0_q != CNT_MAX) done_cnt0_d = done_cnt0_q + CNT_W'(1);
      if (out_id_q && done_cnt1_q != CNT_MAX)  done_cnt1_d = done_cnt1_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_id_q     <= 1'b0;
      out_result_q <= 8'h00;
      out_carry_q  <= 1'b0;
      out_zero_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
      done_cnt0_q  <= '0;
      done_cnt1_q  <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q        <= 1'b0;
`endif
    end else begin
      out_valid_q  <= out_valid_d;
      out_id_q     <= out_id_d;
      out_result_q <= out_result_d;
      out_carry_q  <= out_carry_d;
      out_zero_q   <= out_zero_d;
      out_ovf_q    <= out_ovf_d;
      done_cnt0_q  <= done_cnt0_d;
      done_cnt1_q  <= done_cnt1_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

  assign out_valid    = out_valid_q;
  assign out_id       = out_id_q;
  assign out_result   = out_result_q;
  assign out_carry    = out_carry_q;
  assign out_zero     = out_zero_q;
  assign out_overflow = out_ovf_q;
  assign done_cnt0    = done_cnt0_q;
  assign done_cnt1    = done_cnt1_q;

endmodule
`default_nettype wire
